// File: rtl/coolgirl_pkg.sv
// Shared constants for the CoolGirl mapper slice: register selector codes
// for the MMC3 scanline IRQ block and default build parameters.
package coolgirl_pkg;

  // {A14, A13, A0} codes of the IRQ registers in $C000-$FFFF
  localparam logic [2:0] REG_IRQ_LATCH   = 3'b100;  // $C000
  localparam logic [2:0] REG_IRQ_RELOAD  = 3'b101;  // $C001
  localparam logic [2:0] REG_IRQ_DISABLE = 3'b110;  // $E000
  localparam logic [2:0] REG_IRQ_ENABLE  = 3'b111;  // $E001

  localparam int A12_LOW_MIN_DEFAULT   = 3;
  localparam int COUNTER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/mmc3_scanline_irq_if.sv
// CPU/PPU snoop bus and IRQ result of the MMC3 scanline IRQ unit.
// master = the side driving the buses (mapper top / bench),
// slave  = the IRQ unit itself.
interface mmc3_scanline_irq_if #(
  parameter int COUNTER_WIDTH = 8
);
  logic                     active;
  logic                     romsel;
  logic                     cpu_rw_in;
  logic [14:0]              cpu_addr_in;
  logic [7:0]               cpu_data_in;
  logic                     ppu_a12;
  logic                     irq_req;
  logic [COUNTER_WIDTH-1:0] irq_count;

  modport master (
    output active, romsel, cpu_rw_in, cpu_addr_in, cpu_data_in, ppu_a12,
    input  irq_req, irq_count
  );

  modport slave (
    input  active, romsel, cpu_rw_in, cpu_addr_in, cpu_data_in, ppu_a12,
    output irq_req, irq_count
  );
endinterface

// File: rtl/mmc3_scanline_irq_a12_edge_filter.sv
// PPU A12 rising-edge filter: an edge only counts after A12 has been low
// for at least A12_LOW_MIN consecutive m2 samples, which rejects the
// short A12 toggles seen during sprite/background fetch interleaving.
// The resulting pulse is registered, one m2 cycle wide.
module a12_edge_filter #(
  parameter int A12_LOW_MIN = 3
) (
  input  logic m2,
  input  logic reset,
  input  logic ppu_a12,
  output logic clk_evt
);

  localparam logic [3:0] LOW_MIN_C = 4'(A12_LOW_MIN);

  logic [3:0] low_cnt_r;
  logic       a12_prev_r;
  logic       clk_evt_r;

  // Track A12 low time, previous level, and register the qualified edge
  always_ff @(posedge m2) begin
    if (reset) begin
      low_cnt_r  <= 4'd0;
      a12_prev_r <= 1'b0;
      clk_evt_r  <= 1'b0;
    end else begin
      a12_prev_r <= ppu_a12;
      clk_evt_r  <= ppu_a12 & ~a12_prev_r & (low_cnt_r == LOW_MIN_C);
      if (ppu_a12) begin
        low_cnt_r <= 4'd0;
      end else if (low_cnt_r != LOW_MIN_C) begin
        low_cnt_r <= low_cnt_r + 4'd1;
      end else begin
        low_cnt_r <= low_cnt_r;
      end
    end
  end

  assign clk_evt = clk_evt_r;

endmodule

// File: rtl/mmc3_scanline_irq.sv
// MMC3-style scanline IRQ unit. Snoops CPU writes to $C000-$FFFF and
// counts filtered PPU A12 rising edges; raises irq_req when the
// down-counter reaches zero while enabled.
// Build option: define MMC3_IRQ_REV_A_EN for the older MMC3A behaviour
// (a zero result only fires if the counter was non-zero or a reload was
// pending); otherwise every step that lands on zero fires (MMC3B/C).
module mmc3_scanline_irq
  import coolgirl_pkg::*;
#(
  parameter int A12_LOW_MIN   = A12_LOW_MIN_DEFAULT,
  parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEFAULT
) (
  input  logic                 m2,
  input  logic                 reset,
  mmc3_scanline_irq_if.slave   bus
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = {COUNTER_WIDTH{1'b0}};
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  logic [COUNTER_WIDTH-1:0] latch_r;
  logic [COUNTER_WIDTH-1:0] counter_r;
  logic                     reload_r;
  logic                     irq_en_r;
  logic                     irq_req_r;

  logic [COUNTER_WIDTH-1:0] latch_nxt_s;
  logic [COUNTER_WIDTH-1:0] counter_nxt_s;
  logic [COUNTER_WIDTH-1:0] step_cnt_s;
  logic                     reload_nxt_s;
  logic                     step_reload_s;
  logic                     irq_en_nxt_s;
  logic                     irq_req_nxt_s;
  logic                     fire_cond_s;
  logic                     fire_s;
  logic                     clk_evt_s;
  logic                     step_s;
  logic                     wr_s;
  logic [2:0]               sel_s;
  logic                     unused_addr_s;

  a12_edge_filter #(
    .A12_LOW_MIN (A12_LOW_MIN)
  ) u_a12_edge_filter (
    .m2      (m2),
    .reset   (reset),
    .ppu_a12 (bus.ppu_a12),
    .clk_evt (clk_evt_s)
  );

  assign wr_s          = bus.active & ~bus.romsel & ~bus.cpu_rw_in;
  assign sel_s         = {bus.cpu_addr_in[14], bus.cpu_addr_in[13], bus.cpu_addr_in[0]};
  assign step_s        = clk_evt_s & bus.active;
  assign unused_addr_s = ^bus.cpu_addr_in[12:1];

  // Counter step from pre-write state, then register writes layered on top
  always_comb begin
    step_cnt_s    = counter_r;
    step_reload_s = reload_r;
    fire_cond_s   = 1'b0;
    if (step_s) begin
      if ((counter_r == CNT_ZERO) || reload_r) begin
        step_cnt_s    = latch_r;
        step_reload_s = 1'b0;
      end else begin
        step_cnt_s    = counter_r - CNT_ONE;
        step_reload_s = reload_r;
      end
`ifdef MMC3_IRQ_REV_A_EN
      fire_cond_s = (step_cnt_s == CNT_ZERO) && ((counter_r != CNT_ZERO) || reload_r);
`else
      fire_cond_s = (step_cnt_s == CNT_ZERO);
`endif
    end else begin
      step_cnt_s    = counter_r;
      step_reload_s = reload_r;
      fire_cond_s   = 1'b0;
    end
    fire_s = fire_cond_s & irq_en_r;

    latch_nxt_s   = latch_r;
    counter_nxt_s = step_cnt_s;
    reload_nxt_s  = step_reload_s;
    irq_en_nxt_s  = irq_en_r;
    irq_req_nxt_s = irq_req_r | fire_s;
    if (wr_s) begin
      case (sel_s)
        REG_IRQ_LATCH: begin
          latch_nxt_s = bus.cpu_data_in[COUNTER_WIDTH-1:0];
        end
        REG_IRQ_RELOAD: begin
          counter_nxt_s = CNT_ZERO;
          reload_nxt_s  = 1'b1;
        end
        REG_IRQ_DISABLE: begin
          irq_en_nxt_s  = 1'b0;
          irq_req_nxt_s = 1'b0;
        end
        REG_IRQ_ENABLE: begin
          irq_en_nxt_s = 1'b1;
        end
        default: begin
          latch_nxt_s = latch_r;
        end
      endcase
    end else begin
      latch_nxt_s = latch_r;
    end
  end

  // IRQ state registers with synchronous reset
  always_ff @(posedge m2) begin
    if (reset) begin
      latch_r   <= CNT_ZERO;
      counter_r <= CNT_ZERO;
      reload_r  <= 1'b0;
      irq_en_r  <= 1'b0;
      irq_req_r <= 1'b0;
    end else begin
      latch_r   <= latch_nxt_s;
      counter_r <= counter_nxt_s;
      reload_r  <= reload_nxt_s;
      irq_en_r  <= irq_en_nxt_s;
      irq_req_r <= irq_req_nxt_s;
    end
  end

  // Idle unit never asserts the pin request, but keeps its pending state
  assign bus.irq_req   = irq_req_r & bus.active;
  assign bus.irq_count = counter_r;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Directed self-checking bench for mmc3_scanline_irq (A12_LOW_MIN=3, CW=8).
module tb_mmc3_scanline_irq;

  logic m2;
  logic reset;
  int   n_cmp;
  int   n_bad;

  mmc3_scanline_irq_if #(.COUNTER_WIDTH(8)) bus ();

  mmc3_scanline_irq #(
    .A12_LOW_MIN   (3),
    .COUNTER_WIDTH (8)
  ) dut (
    .m2    (m2),
    .reset (reset),
    .bus   (bus)
  );

  initial m2 = 1'b0;
  always #5 m2 = ~m2;

  // inputs change and outputs are sampled at the falling edge
  task automatic cyc();
    @(negedge m2);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bus.cpu_addr_in = a[14:0];
    bus.cpu_data_in = d;
    bus.romsel      = 1'b0;
    bus.cpu_rw_in   = 1'b0;
    cyc();
    bus.romsel      = 1'b1;
    bus.cpu_rw_in   = 1'b1;
  endtask

  // n low samples, then a rising edge; returns after the counter step
  task automatic a12_edge(input int n);
    bus.ppu_a12 = 1'b0;
    repeat (n) cyc();
    bus.ppu_a12 = 1'b1;
    cyc();
    cyc();
    bus.ppu_a12 = 1'b0;
  endtask

  task automatic test_reset();
    bus.active      = 1'b1;
    bus.romsel      = 1'b1;
    bus.cpu_rw_in   = 1'b1;
    bus.cpu_addr_in = 15'h0000;
    bus.cpu_data_in = 8'h00;
    bus.ppu_a12     = 1'b0;
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    n_cmp++;
    if (bus.irq_count !== 8'd0) begin
      $display("FAIL reset_count actual=%0d expected=0", bus.irq_count);
      n_bad++;
    end
    n_cmp++;
    if (bus.irq_req !== 1'b0) begin
      $display("FAIL reset_irq actual=%0b expected=0", bus.irq_req);
      n_bad++;
    end
  endtask

  task automatic test_countdown();
    logic [7:0] exp_c;
    logic       exp_r;
    cpu_write(16'hC000, 8'd5);
    cpu_write(16'hC001, 8'd0);
    cpu_write(16'hE001, 8'd0);
    for (int i = 0; i < 6; i++) begin
      a12_edge(3);
      exp_c = 8'(5 - i);
      exp_r = (i == 5);
      n_cmp++;
      if (bus.irq_count !== exp_c) begin
        $display("FAIL countdown_count edge=%0d actual=%0d expected=%0d", i + 1, bus.irq_count, exp_c);
        n_bad++;
      end
      n_cmp++;
      if (bus.irq_req !== exp_r) begin
        $display("FAIL countdown_irq edge=%0d actual=%0b expected=%0b", i + 1, bus.irq_req, exp_r);
        n_bad++;
      end
    end
  endtask

  task automatic test_filter();
    cpu_write(16'hE000, 8'd0);
    cpu_write(16'hC000, 8'd7);
    cpu_write(16'hC001, 8'd0);
    a12_edge(3);
    n_cmp++;
    if (bus.irq_count !== 8'd7) begin
      $display("FAIL filter_load actual=%0d expected=7", bus.irq_count);
      n_bad++;
    end
    a12_edge(2);
    a12_edge(2);
    n_cmp++;
    if (bus.irq_count !== 8'd7) begin
      $display("FAIL filter_short_low actual=%0d expected=7", bus.irq_count);
      n_bad++;
    end
    a12_edge(3);
    n_cmp++;
    if (bus.irq_count !== 8'd6) begin
      $display("FAIL filter_three_low actual=%0d expected=6", bus.irq_count);
      n_bad++;
    end
  endtask

  task automatic test_latch_zero();
    logic exp_r;
    cpu_write(16'hE000, 8'd0);
    cpu_write(16'hC000, 8'd0);
    cpu_write(16'hC001, 8'd0);
    cpu_write(16'hE001, 8'd0);
    for (int i = 0; i < 3; i++) begin
      a12_edge(3);
`ifdef MMC3_IRQ_REV_A_EN
      exp_r = (i == 0);
`else
      exp_r = 1'b1;
`endif
      n_cmp++;
      if (bus.irq_req !== exp_r) begin
        $display("FAIL latch_zero_irq edge=%0d actual=%0b expected=%0b", i + 1, bus.irq_req, exp_r);
        n_bad++;
      end
      n_cmp++;
      if (bus.irq_count !== 8'd0) begin
        $display("FAIL latch_zero_count edge=%0d actual=%0d expected=0", i + 1, bus.irq_count);
        n_bad++;
      end
      cpu_write(16'hE000, 8'd0);
      cpu_write(16'hE001, 8'd0);
    end
  endtask

  task automatic test_ack_collision();
    logic [7:0] exp_c;
    logic       exp_r;
    cpu_write(16'hC000, 8'd2);
    cpu_write(16'hC001, 8'd0);
    cpu_write(16'hE001, 8'd0);
    a12_edge(3);
    a12_edge(3);
    n_cmp++;
    if (bus.irq_count !== 8'd1) begin
      $display("FAIL collide_setup actual=%0d expected=1", bus.irq_count);
      n_bad++;
    end
    // the firing step lands in the same m2 cycle as the $E000 write
    bus.ppu_a12 = 1'b0;
    repeat (3) cyc();
    bus.ppu_a12 = 1'b1;
    cyc();
    cpu_write(16'hE000, 8'd0);
    bus.ppu_a12 = 1'b0;
    n_cmp++;
    if (bus.irq_count !== 8'd0) begin
      $display("FAIL collide_count actual=%0d expected=0", bus.irq_count);
      n_bad++;
    end
    n_cmp++;
    if (bus.irq_req !== 1'b0) begin
      $display("FAIL collide_irq actual=%0b expected=0", bus.irq_req);
      n_bad++;
    end
    cpu_write(16'hE001, 8'd0);
    for (int i = 0; i < 3; i++) begin
      a12_edge(3);
      exp_c = (i == 0) ? 8'd2 : ((i == 1) ? 8'd1 : 8'd0);
      exp_r = (i == 2);
      n_cmp++;
      if (bus.irq_count !== exp_c) begin
        $display("FAIL refire_count edge=%0d actual=%0d expected=%0d", i + 1, bus.irq_count, exp_c);
        n_bad++;
      end
      n_cmp++;
      if (bus.irq_req !== exp_r) begin
        $display("FAIL refire_irq edge=%0d actual=%0b expected=%0b", i + 1, bus.irq_req, exp_r);
        n_bad++;
      end
    end
  endtask

  task automatic test_inactive();
    bus.active = 1'b0;
    cyc();
    n_cmp++;
    if (bus.irq_req !== 1'b0) begin
      $display("FAIL inactive_irq_mask actual=%0b expected=0", bus.irq_req);
      n_bad++;
    end
    cpu_write(16'hC000, 8'd9);
    cpu_write(16'hC001, 8'd0);
    a12_edge(3);
    a12_edge(3);
    n_cmp++;
    if (bus.irq_count !== 8'd0) begin
      $display("FAIL inactive_count actual=%0d expected=0", bus.irq_count);
      n_bad++;
    end
    n_cmp++;
    if (bus.irq_req !== 1'b0) begin
      $display("FAIL inactive_irq actual=%0b expected=0", bus.irq_req);
      n_bad++;
    end
    bus.active = 1'b1;
    cyc();
    n_cmp++;
    if (bus.irq_req !== 1'b1) begin
      $display("FAIL reactive_irq_held actual=%0b expected=1", bus.irq_req);
      n_bad++;
    end
    a12_edge(3);
    n_cmp++;
    if (bus.irq_count !== 8'd2) begin
      $display("FAIL reactive_latch_kept actual=%0d expected=2", bus.irq_count);
      n_bad++;
    end
  endtask

  task automatic test_reset_mid_count();
    logic exp_r;
    cpu_write(16'hC000, 8'd3);
    cpu_write(16'hC001, 8'd0);
    a12_edge(3);
    n_cmp++;
    if (bus.irq_count !== 8'd3 || bus.irq_req !== 1'b1) begin
      $display("FAIL midreset_setup actual=%0d/%0b expected=3/1", bus.irq_count, bus.irq_req);
      n_bad++;
    end
    // edge registered, reset lands on the cycle the step would happen
    bus.ppu_a12 = 1'b0;
    repeat (3) cyc();
    bus.ppu_a12 = 1'b1;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.ppu_a12 = 1'b0;
    n_cmp++;
    if (bus.irq_count !== 8'd0 || bus.irq_req !== 1'b0) begin
      $display("FAIL midreset_outputs actual=%0d/%0b expected=0/0", bus.irq_count, bus.irq_req);
      n_bad++;
    end
    cyc();
    n_cmp++;
    if (bus.irq_count !== 8'd0) begin
      $display("FAIL midreset_edge_dropped actual=%0d expected=0", bus.irq_count);
      n_bad++;
    end
    a12_edge(3);
    n_cmp++;
    if (bus.irq_count !== 8'd0 || bus.irq_req !== 1'b0) begin
      $display("FAIL midreset_reload_zero actual=%0d/%0b expected=0/0", bus.irq_count, bus.irq_req);
      n_bad++;
    end
    cpu_write(16'hE001, 8'd0);
    a12_edge(3);
`ifdef MMC3_IRQ_REV_A_EN
    exp_r = 1'b0;
`else
    exp_r = 1'b1;
`endif
    n_cmp++;
    if (bus.irq_req !== exp_r) begin
      $display("FAIL midreset_zero_fire actual=%0b expected=%0b", bus.irq_req, exp_r);
      n_bad++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    test_reset();
    test_countdown();
    test_filter();
    test_latch_zero();
    test_ack_collision();
    test_inactive();
    test_reset_mid_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
